axi_lite_reg_bank: RTL and testbench

//  Parametrised AXI4-Lite register bank. It replaces fixed per-signal register decode with NUM_REGS

---
 rtl/axi_lite_reg_bank_pkg.sv | 30 +++
 rtl/axi_lite_slave_if.sv | 132 +++++++++++++
 rtl/axi_lite_reg_bank.sv | 167 ++++++++++++++++
 tb/tb_axi_lite_reg_bank.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_reg_bank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
package reg_bank_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam int         MAX_REGS        = 256;

  typedef enum logic [1:0] {
    REG_RW    = 2'b00,
    REG_RO    = 2'b01,
    REG_W1C   = 2'b10,
    REG_PULSE = 2'b11
  } reg_type_e;

  // PULSE overrides RW because a pulse register is also listed in the RW mask
  function automatic reg_type_e reg_type(input int i,
                                         input logic [MAX_REGS-1:0] rw_mask,
                                         input logic [MAX_REGS-1:0] w1c_mask,
                                         input logic [MAX_REGS-1:0] pulse_mask);
    logic [7:0] idx;
    reg_type_e  t;
    idx = 8'(i);
    if (pulse_mask[idx])      t = REG_PULSE;
    else if (w1c_mask[idx])   t = REG_W1C;
    else if (rw_mask[idx])    t = REG_RW;
    else                      t = REG_RO;
    return t;
  endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite handshake engine: captures AW/W independently, issues one commit
// per B response, and registers read data for the R channel.
module axi_lite_slave_if
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 16,
  localparam int IDX_W   = ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic              wr_err_o,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  logic              r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic              r_awready, r_wready, r_arready;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata, r_rdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp, r_rresp;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_wr_go;
  logic w_aw_held_n, w_w_held_n, w_bvalid_n, w_rvalid_n;
  logic w_unused;

  always_comb begin
    w_aw_hs = s_axi_awvalid & r_awready;
    w_w_hs  = s_axi_wvalid & r_wready;
    w_ar_hs = s_axi_arvalid & r_arready;
    w_wr_go = r_aw_held & r_w_held;

    if (w_aw_hs)      w_aw_held_n = 1'b1;
    else if (w_wr_go) w_aw_held_n = 1'b0;
    else              w_aw_held_n = r_aw_held;

    if (w_w_hs)       w_w_held_n = 1'b1;
    else if (w_wr_go) w_w_held_n = 1'b0;
    else              w_w_held_n = r_w_held;

    if (w_wr_go)           w_bvalid_n = 1'b1;
    else if (s_axi_bready) w_bvalid_n = 1'b0;
    else                   w_bvalid_n = r_bvalid;

    if (w_ar_hs)           w_rvalid_n = 1'b1;
    else if (s_axi_rready) w_rvalid_n = 1'b0;
    else                   w_rvalid_n = r_rvalid;
  end

  // Ready flags are registered from next-state so they are 0 throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_bresp   <= AXI_RESP_OKAY;
      r_rdata   <= 32'h0;
      r_rresp   <= AXI_RESP_OKAY;
    end else begin
      r_aw_held <= w_aw_held_n;
      r_w_held  <= w_w_held_n;
      r_bvalid  <= w_bvalid_n;
      r_rvalid  <= w_rvalid_n;
      r_awready <= ~w_aw_held_n & ~w_bvalid_n;
      r_wready  <= ~w_w_held_n & ~w_bvalid_n;
      r_arready <= ~w_rvalid_n;
      if (w_aw_hs) r_awaddr <= s_axi_awaddr;
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
      end
      if (w_wr_go) r_bresp <= wr_err_o ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      if (w_ar_hs) begin
        r_rdata <= rd_data;
        r_rresp <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  assign wr_en    = w_wr_go;
  assign wr_idx   = r_awaddr[ADDR_W-1:2];
  assign wr_data  = r_wdata;
  assign wr_strb  = r_wstrb;
  assign wr_err_o = {{(32-IDX_W){1'b0}}, wr_idx} >= 32'(NUM_REGS);
  assign rd_en    = w_ar_hs;
  assign rd_idx   = s_axi_araddr[ADDR_W-1:2];

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

  assign w_unused = ^{s_axi_awprot, s_axi_arprot, r_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: rtl/axi_lite_reg_bank.sv
// Generic AXI4-Lite register bank (RW / RO / W1C / PULSE registers).
// Optional interrupt output enabled by defining REG_BANK_IRQ_EN.
module axi_lite_reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                     C_S_AXI_DATA_WIDTH = 32,
  parameter int                     C_S_AXI_ADDR_WIDTH = 8,
  parameter int                     NUM_REGS           = 16,
  parameter logic [NUM_REGS-1:0]    RW_MASK            = 16'h00FF,
  parameter logic [NUM_REGS-1:0]    W1C_MASK           = 16'h0100,
  parameter logic [NUM_REGS-1:0]    PULSE_MASK         = 16'h0001,
  parameter logic [NUM_REGS*32-1:0] RESET_VALUE        = '0
`ifdef REG_BANK_IRQ_EN
  ,
  parameter int                     IRQ_STATUS_IDX     = 8,
  parameter int                     IRQ_ENABLE_IDX     = 7
`endif
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [NUM_REGS*32-1:0]          hw_ro_value,
  input  logic [NUM_REGS*32-1:0]          hw_set,
  output logic [NUM_REGS*32-1:0]          reg_value,
  output logic [NUM_REGS-1:0]             reg_wr_pulse
`ifdef REG_BANK_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  logic             w_wr_en, w_wr_err, w_rd_en, w_rd_err;
  logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
  logic [31:0]      w_wr_data, w_rd_data, w_byte_mask, w_wdata_m;
  logic [3:0]       w_wr_strb;

  logic [NUM_REGS-1:0][31:0] w_regs;
  logic [NUM_REGS*32-1:0]    w_rd_src;
  logic [NUM_REGS-1:0]       w_sel;
  logic [NUM_REGS-1:0]       r_wr_pulse;

  axi_lite_slave_if #(
    .ADDR_W   (C_S_AXI_ADDR_WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_if (
    .clk           (s00_axi_aclk),
    .rst_n         (s00_axi_aresetn),
    .s_axi_awaddr  (s00_axi_awaddr),
    .s_axi_awprot  (s00_axi_awprot),
    .s_axi_awvalid (s00_axi_awvalid),
    .s_axi_awready (s00_axi_awready),
    .s_axi_wdata   (s00_axi_wdata),
    .s_axi_wstrb   (s00_axi_wstrb),
    .s_axi_wvalid  (s00_axi_wvalid),
    .s_axi_wready  (s00_axi_wready),
    .s_axi_bresp   (s00_axi_bresp),
    .s_axi_bvalid  (s00_axi_bvalid),
    .s_axi_bready  (s00_axi_bready),
    .s_axi_araddr  (s00_axi_araddr),
    .s_axi_arprot  (s00_axi_arprot),
    .s_axi_arvalid (s00_axi_arvalid),
    .s_axi_arready (s00_axi_arready),
    .s_axi_rdata   (s00_axi_rdata),
    .s_axi_rresp   (s00_axi_rresp),
    .s_axi_rvalid  (s00_axi_rvalid),
    .s_axi_rready  (s00_axi_rready),
    .wr_en         (w_wr_en),
    .wr_idx        (w_wr_idx),
    .wr_data       (w_wr_data),
    .wr_strb       (w_wr_strb),
    .wr_err_o      (w_wr_err),
    .rd_en         (w_rd_en),
    .rd_idx        (w_rd_idx),
    .rd_data       (w_rd_data),
    .rd_err        (w_rd_err)
  );

  assign w_byte_mask = {{8{w_wr_strb[3]}}, {8{w_wr_strb[2]}}, {8{w_wr_strb[1]}}, {8{w_wr_strb[0]}}};
  assign w_wdata_m   = w_wr_data & w_byte_mask;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      localparam reg_type_e   T   = reg_type(g, MAX_REGS'(RW_MASK), MAX_REGS'(W1C_MASK),
                                             MAX_REGS'(PULSE_MASK));
      localparam logic [31:0] RST = RESET_VALUE[g*32 +: 32];

      logic [31:0] r_reg;
      logic [31:0] w_hw_set, w_hw_ro;
      logic        w_unused;

      assign w_hw_set = hw_set[g*32 +: 32];
      assign w_hw_ro  = hw_ro_value[g*32 +: 32];
      assign w_unused = ^{w_hw_set, w_hw_ro};
      assign w_sel[g] = w_wr_en & ~w_wr_err & (w_wr_idx == IDX_W'(g));

      // W1C: set from hardware is OR-ed in after the clear, so set wins a tie
      always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
          r_reg <= RST;
        end else begin
          case (T)
            REG_RW: begin
              if (w_sel[g]) r_reg <= (r_reg & ~w_byte_mask) | w_wdata_m;
            end
            REG_PULSE: begin
              if (w_sel[g])           r_reg <= (r_reg & ~w_byte_mask) | w_wdata_m;
              else if (r_wr_pulse[g]) r_reg <= RST;
            end
            REG_W1C: begin
              r_reg <= (r_reg & ~(w_sel[g] ? w_wdata_m : 32'h0)) | w_hw_set;
            end
            default: begin
              r_reg <= w_hw_ro;
            end
          endcase
        end
      end

      assign w_regs[g]             = r_reg;
      assign w_rd_src[g*32 +: 32]  = (T == REG_RO) ? w_hw_ro : r_reg;
    end
  endgenerate

  assign w_rd_err  = {{(32-IDX_W){1'b0}}, w_rd_idx} >= 32'(NUM_REGS);
  assign w_rd_data = (w_rd_en && !w_rd_err) ? 32'(w_rd_src >> {w_rd_idx, 5'b00000}) : 32'h0;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_wr_pulse <= '0;
    else                  r_wr_pulse <= w_sel;
  end

  assign reg_value    = w_regs;
  assign reg_wr_pulse = r_wr_pulse;

`ifdef REG_BANK_IRQ_EN
  logic r_irq;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_irq <= 1'b0;
    else                  r_irq <= |(w_regs[IRQ_STATUS_IDX] & w_regs[IRQ_ENABLE_IDX]);
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed self-checking bench for axi_lite_reg_bank (default parameters).
// Define REG_BANK_IRQ_EN to also exercise the interrupt output.
module tb_axi_lite_reg_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] hw_ro_value, hw_set, reg_value, snap;
  logic [15:0]  reg_wr_pulse, pulse_q;
  logic [31:0]  rd_q;
  logic [1:0]   resp_q;
`ifdef REG_BANK_IRQ_EN
  logic         irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_lite_reg_bank dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .hw_ro_value     (hw_ro_value),
    .hw_set          (hw_set),
    .reg_value       (reg_value),
    .reg_wr_pulse    (reg_wr_pulse)
`ifdef REG_BANK_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulse);
    awaddr = a; awvalid = 1'b1;
    wdata  = d; wstrb   = s; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 8 && !bvalid; n++) step();
    chk("b_wait", bvalid, 1'b1);
    resp  = bresp;
    pulse = reg_wr_pulse;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    araddr = a; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    for (int n = 0; n < 8 && !rvalid; n++) step();
    chk("r_wait", rvalid, 1'b1);
    d    = rdata;
    resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awaddr = 8'h00; araddr = 8'h00; awprot = 3'b000; arprot = 3'b000;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = 32'h0; wstrb = 4'h0;
    hw_ro_value = '0; hw_set = '0;
    step(); step(); step();

    // reset state
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready",  wready,  1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid",  bvalid,  1'b0);
    chk("rst_rvalid",  rvalid,  1'b0);
    chk("rst_resp",    {bresp, rresp}, 4'b0000);
    chk("rst_rdata",   rdata, 32'h0);
    chk("rst_pulse",   reg_wr_pulse, 16'h0000);
    checks++;
    assert (reg_value === 512'h0) else begin
      errors++;
      $error("FAIL rst_regs: observed=%0h expected=0", reg_value);
    end

    rst_n = 1'b1;
    step(); step();
    chk("idle_awready", awready, 1'b1);
    chk("idle_arready", arready, 1'b1);

    // 1: AW first, W three cycles later
    awaddr = 8'h08; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("t1_awready_held", awready, 1'b0);
    chk("t1_wready_open",  wready,  1'b1);
    step(); step();
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("t1_bvalid_early", bvalid, 1'b0);
    step();
    chk("t1_bvalid", bvalid, 1'b1);
    chk("t1_bresp",  bresp,  2'b00);
    chk("t1_pulse",  reg_wr_pulse, 16'h0004);
    chk("t1_reg2",   reg_value[2*32 +: 32], 32'hDEADBEEF);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("t1_bvalid_clr", bvalid, 1'b0);
    do_read(8'h08, rd_q, resp_q);
    chk("t1_rdata", rd_q, 32'hDEADBEEF);
    chk("t1_rresp", resp_q, 2'b00);

    // 2: byte strobe
    do_write(8'h0C, 32'hFFFF_FFFF, 4'b0010, resp_q, pulse_q);
    chk("t2_bresp", resp_q, 2'b00);
    chk("t2_pulse", pulse_q, 16'h0008);
    do_read(8'h0C, rd_q, resp_q);
    chk("t2_rdata", rd_q, 32'h0000_FF00);

    // 3: W1C set/clear, set wins on collision; hw_set on an RW reg is ignored
    hw_set[8*32+4] = 1'b1; hw_set[1*32+0] = 1'b1;
    step();
    hw_set = '0;
    chk("t3_reg8_set", reg_value[8*32 +: 32], 32'h10);
    chk("t3_reg1_ign", reg_value[1*32 +: 32], 32'h0);
    do_read(8'h20, rd_q, resp_q);
    chk("t3_rdata", rd_q, 32'h10);
    awaddr = 8'h20; awvalid = 1'b1; wdata = 32'h10; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    hw_set[8*32+4] = 1'b1;
    step();
    hw_set = '0;
    chk("t3_collide_bvalid", bvalid, 1'b1);
    chk("t3_collide_reg8",   reg_value[8*32 +: 32], 32'h10);
    bready = 1'b1;
    step();
    bready = 1'b0;
    do_write(8'h20, 32'h10, 4'hF, resp_q, pulse_q);
    do_read(8'h20, rd_q, resp_q);
    chk("t3_cleared", rd_q, 32'h0);

    // 4: PULSE register
    awaddr = 8'h00; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("t4_reg0_hi",  reg_value[31:0], 32'h1);
    chk("t4_pulse_hi", reg_wr_pulse, 16'h0001);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("t4_reg0_lo",  reg_value[31:0], 32'h0);
    chk("t4_pulse_lo", reg_wr_pulse, 16'h0000);
    do_read(8'h00, rd_q, resp_q);
    chk("t4_rdata", rd_q, 32'h0);

    // 5: out-of-range index 20
    snap = reg_value;
    do_write(8'h50, 32'hFFFF_FFFF, 4'hF, resp_q, pulse_q);
    chk("t5_bresp", resp_q, 2'b10);
    chk("t5_pulse", pulse_q, 16'h0000);
    checks++;
    assert (reg_value === snap) else begin
      errors++;
      $error("FAIL t5_regs: observed=%0h expected=%0h", reg_value, snap);
    end
    do_read(8'h50, rd_q, resp_q);
    chk("t5_rdata", rd_q, 32'h0);
    chk("t5_rresp", resp_q, 2'b10);

    // RO register: write ignored, read returns live hardware value
    hw_ro_value[9*32 +: 32] = 32'hCAFE1234;
    do_write(8'h24, 32'h0, 4'hF, resp_q, pulse_q);
    chk("ro_bresp", resp_q, 2'b00);
    do_read(8'h24, rd_q, resp_q);
    chk("ro_rdata", rd_q, 32'hCAFE1234);

    // Same-cycle read and write of reg 5: read sees the old value
    do_write(8'h14, 32'h1111_1111, 4'hF, resp_q, pulse_q);
    awaddr = 8'h14; awvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h14; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("rw_rvalid", rvalid, 1'b1);
    chk("rw_rdata",  rdata,  32'h1111_1111);
    chk("rw_bvalid", bvalid, 1'b1);
    chk("rw_reg5",   reg_value[5*32 +: 32], 32'h2222_2222);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;

    // Backpressure on B then on R
    awaddr = 8'h18; awvalid = 1'b1; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_bvalid",  bvalid,  1'b1);
      chk("bp_bresp",   bresp,   2'b00);
      chk("bp_awready", awready, 1'b0);
      chk("bp_wready",  wready,  1'b0);
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    araddr = 8'h18; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rvalid",  rvalid,  1'b1);
      chk("bp_rdata",   rdata,   32'h5A5A_5A5A);
      chk("bp_arready", arready, 1'b0);
      step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("bp_rvalid_clr", rvalid, 1'b0);
    chk("bp_arready_re", arready, 1'b1);

`ifdef REG_BANK_IRQ_EN
    // 6: interrupt
    do_write(8'h1C, 32'h10, 4'hF, resp_q, pulse_q);
    hw_set[8*32+4] = 1'b1;
    step();
    hw_set = '0;
    chk("irq_not_yet", irq, 1'b0);
    step();
    chk("irq_set", irq, 1'b1);
    awaddr = 8'h20; awvalid = 1'b1; wdata = 32'h10; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("irq_commit_reg8", reg_value[8*32 +: 32], 32'h0);
    chk("irq_still_hi", irq, 1'b1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("irq_clr", irq, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
